// File: rtl/pvr_plane_setup_if.sv
// pvr_plane_setup_if: control, vertex/attribute and result-stream bundle for
// the plane-equation setup block.
//   master : start, v1..v3 x/y, attr_v1..3, out_ready          (driven)
//            busy, done, degenerate, culled, out_valid, out_idx,
//            out_ddx, out_ddy, out_c, out_C                    (observed)
//   slave  : the mirror image, used by pvr_plane_setup.
interface pvr_plane_setup_if #(
    parameter int NUM_ATTR = 4,
    parameter int W        = 32
);
    logic                       start;
    logic                       busy;
    logic                       done;
    logic                       degenerate;
    logic                       culled;
    logic signed [W-1:0]        v1_x, v1_y, v2_x, v2_y, v3_x, v3_y;
    logic [NUM_ATTR*W-1:0]      attr_v1, attr_v2, attr_v3;
    logic                       out_valid;
    logic                       out_ready;
    logic [3:0]                 out_idx;
    logic signed [W-1:0]        out_ddx, out_ddy, out_c, out_C;

    modport master (
        output start, v1_x, v1_y, v2_x, v2_y, v3_x, v3_y,
               attr_v1, attr_v2, attr_v3, out_ready,
        input  busy, done, degenerate, culled, out_valid, out_idx,
               out_ddx, out_ddy, out_c, out_C
    );

    modport slave (
        input  start, v1_x, v1_y, v2_x, v2_y, v3_x, v3_y,
               attr_v1, attr_v2, attr_v3, out_ready,
        output busy, done, degenerate, culled, out_valid, out_idx,
               out_ddx, out_ddy, out_c, out_C
    );
endinterface

// File: rtl/pvr_plane_setup.sv
// pvr_plane_setup: sequential triangle plane-equation setup.
// For each of NUM_ATTR attributes produces ddx, ddy and c such that
// attr(x,y) = x*ddx + y*ddy + c, using a shared multiply path and one
// W-cycle restoring divider.
// Ports:
//   clock   : system clock
//   reset_n : asynchronous active-low reset
//   bus     : pvr_plane_setup_if.slave (start/busy/done, vertices,
//             attributes, result stream with valid/ready, area term out_C)
// Optional: define PLANE_SETUP_CULL_EN to finish negative-area triangles
// immediately with culled=1.
module pvr_plane_setup #(
    parameter int FRAC_BITS = 8,
    parameter int NUM_ATTR  = 4,
    parameter int W         = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    pvr_plane_setup_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_CALC_C, S_ATTR_AB, S_DIV_X, S_DIV_Y, S_OFS, S_OUT, S_FIN
    } state_t;

    localparam int            CW      = $clog2(W);
    localparam logic [W-1:0]  SAT_MAG = {1'b0, {(W-1){1'b1}}};

    // Fixed-point product: full 2W-bit signed product, floor shift, truncate.
    function automatic logic signed [W-1:0] fx_mul(input logic signed [W-1:0] a,
                                                   input logic signed [W-1:0] b);
        logic signed [2*W-1:0] p;
        p = (2*W)'(a) * (2*W)'(b);
        return W'(p >>> FRAC_BITS);
    endfunction

    // Divider start for quotient (-num << FRAC_BITS) / C on magnitudes.
    // Returns {overflow, negative, remainder init, dividend low word}.
    // Overflow means the quotient needs more than W bits.
    function automatic logic [2*W+1:0] div_init(input logic signed [W-1:0] num,
                                                input logic [W-1:0]        dsr,
                                                input logic                cneg);
        logic [W-1:0]   mag;
        logic [2*W-1:0] dvd;
        mag = num[W-1] ? W'(-num) : num;
        dvd = {{W{1'b0}}, mag} << FRAC_BITS;
        return {dvd[2*W-1:W] >= dsr, (num > 0) ^ cneg, dvd};
    endfunction

    state_t                 state_q;
    logic [3:0]             idx_q, oidx_q;
    logic [CW-1:0]          cnt_q;
    logic signed [W-1:0]    v1x_q, v1y_q, v2x_q, v2y_q, v3x_q, v3y_q;
    logic [NUM_ATTR*W-1:0]  a1_q, a2_q, a3_q;
    logic signed [W-1:0]    c_q, ba_q, ddx_q, ddy_q;
    logic [W-1:0]           dsr_q, rem_q, dvd_q;
    logic [W-2:0]           quo_q;
    logic                   neg_q, ovf_q;
    logic                   busy_q, done_q, degen_q, culled_q, valid_q;
    logic signed [W-1:0]    odx_q, ody_q, oc_q;

    logic signed [W-1:0]    cur_a1, cur_a2, cur_a3;
    logic signed [W-1:0]    ma0, mb0, ma1, mb1, ma2, mb2, ma3, mb3;
    logic signed [W-1:0]    diff01, diff23, ofs_c;
    logic [W:0]             rem_sh;
    logic [W-1:0]           rem_nx, q_mag;
    logic [W-1:0]           quo_nx;
    logic signed [W-1:0]    q_res;

    // Shared multiply path: operands chosen by state.
    always_comb begin
        cur_a1 = a1_q[idx_q*W +: W];
        cur_a2 = a2_q[idx_q*W +: W];
        cur_a3 = a3_q[idx_q*W +: W];
        ma0 = '0; mb0 = '0; ma1 = '0; mb1 = '0;
        ma2 = '0; mb2 = '0; ma3 = '0; mb3 = '0;
        case (state_q)
            S_CALC_C: begin
                ma0 = v2x_q - v1x_q;   mb0 = v3y_q - v1y_q;
                ma1 = v3x_q - v1x_q;   mb1 = v2y_q - v1y_q;
            end
            S_ATTR_AB: begin
                ma0 = cur_a3 - cur_a1; mb0 = v2y_q - v1y_q;
                ma1 = cur_a2 - cur_a1; mb1 = v3y_q - v1y_q;
                ma2 = v3x_q - v1x_q;   mb2 = cur_a2 - cur_a1;
                ma3 = v2x_q - v1x_q;   mb3 = cur_a3 - cur_a1;
            end
            S_OFS: begin
                ma0 = ddx_q;           mb0 = v1x_q;
                ma1 = ddy_q;           mb1 = v1y_q;
            end
            default: ;
        endcase
        diff01 = fx_mul(ma0, mb0) - fx_mul(ma1, mb1);
        diff23 = fx_mul(ma2, mb2) - fx_mul(ma3, mb3);
        ofs_c  = cur_a1 - fx_mul(ma0, mb0) - fx_mul(ma1, mb1);
    end

    // One restoring step; the quotient of the final step is used unregistered.
    always_comb begin
        rem_sh = {rem_q, dvd_q[W-1]};
        if (rem_sh >= {1'b0, dsr_q}) begin
            rem_nx = rem_sh[W-1:0] - dsr_q;
            quo_nx = {quo_q, 1'b1};
        end else begin
            rem_nx = rem_sh[W-1:0];
            quo_nx = {quo_q, 1'b0};
        end
        q_mag = (ovf_q || quo_nx[W-1]) ? SAT_MAG : quo_nx;
        q_res = neg_q ? -q_mag : q_mag;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;  oidx_q <= '0;  cnt_q <= '0;
            v1x_q    <= '0;  v1y_q  <= '0;  v2x_q <= '0;
            v2y_q    <= '0;  v3x_q  <= '0;  v3y_q <= '0;
            a1_q     <= '0;  a2_q   <= '0;  a3_q  <= '0;
            c_q      <= '0;  ba_q   <= '0;  ddx_q <= '0;  ddy_q <= '0;
            dsr_q    <= '0;  rem_q  <= '0;  dvd_q <= '0;  quo_q <= '0;
            neg_q    <= 1'b0; ovf_q <= 1'b0;
            busy_q   <= 1'b0; done_q <= 1'b0; degen_q <= 1'b0;
            culled_q <= 1'b0; valid_q <= 1'b0;
            odx_q    <= '0;  ody_q  <= '0;  oc_q  <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: if (bus.start) begin
                    v1x_q <= bus.v1_x; v1y_q <= bus.v1_y;
                    v2x_q <= bus.v2_x; v2y_q <= bus.v2_y;
                    v3x_q <= bus.v3_x; v3y_q <= bus.v3_y;
                    a1_q  <= bus.attr_v1;
                    a2_q  <= bus.attr_v2;
                    a3_q  <= bus.attr_v3;
                    busy_q   <= 1'b1;
                    degen_q  <= 1'b0;
                    culled_q <= 1'b0;
                    state_q  <= S_CALC_C;
                end
                S_CALC_C: begin
                    c_q   <= diff01;
                    dsr_q <= diff01[W-1] ? W'(-diff01) : diff01;
                    idx_q <= '0;
                    if (diff01 == '0) begin
                        degen_q <= 1'b1;
                        state_q <= S_FIN;
                    end
`ifdef PLANE_SETUP_CULL_EN
                    else if (diff01[W-1]) begin
                        culled_q <= 1'b1;
                        state_q  <= S_FIN;
                    end
`endif
                    else begin
                        state_q <= S_ATTR_AB;
                    end
                end
                S_ATTR_AB: begin
                    ba_q <= diff23;
                    {ovf_q, neg_q, rem_q, dvd_q} <= div_init(diff01, dsr_q, c_q[W-1]);
                    quo_q   <= '0;
                    cnt_q   <= '0;
                    state_q <= S_DIV_X;
                end
                S_DIV_X, S_DIV_Y: begin
                    if (cnt_q == CW'(W-1)) begin
                        if (state_q == S_DIV_X) begin
                            ddx_q <= q_res;
                            // Divider restarts straight away on Ba.
                            {ovf_q, neg_q, rem_q, dvd_q} <= div_init(ba_q, dsr_q, c_q[W-1]);
                            quo_q   <= '0;
                            cnt_q   <= '0;
                            state_q <= S_DIV_Y;
                        end else begin
                            ddy_q   <= q_res;
                            state_q <= S_OFS;
                        end
                    end else begin
                        rem_q <= rem_nx;
                        dvd_q <= dvd_q << 1;
                        quo_q <= quo_nx[W-2:0];
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_OFS: begin
                    odx_q   <= ddx_q;
                    ody_q   <= ddy_q;
                    oc_q    <= ofs_c;
                    oidx_q  <= idx_q;
                    valid_q <= 1'b1;
                    state_q <= S_OUT;
                end
                S_OUT: if (bus.out_ready) begin
                    valid_q <= 1'b0;
                    if (idx_q == 4'(NUM_ATTR-1)) begin
                        state_q <= S_FIN;
                    end else begin
                        idx_q   <= idx_q + 4'd1;
                        state_q <= S_ATTR_AB;
                    end
                end
                S_FIN: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.degenerate = degen_q;
    assign bus.culled     = culled_q;
    assign bus.out_valid  = valid_q;
    assign bus.out_idx    = oidx_q;
    assign bus.out_ddx    = odx_q;
    assign bus.out_ddy    = ody_q;
    assign bus.out_c      = oc_q;
    assign bus.out_C      = c_q;
endmodule
